// File: rtl/i2s_output.sv
// I2S transmitter: sample FIFO feeding a 32-slot I2S frame.
// One 16-bit sample is popped per frame and sent on both left and right
// channels. BCLK is derived from i_Clock by a half-period divider; LRCLK and
// SDATA change only on BCLK falling events.
module i2s_output #(
    parameter int CLKS_PER_BCLK_HALF = 4,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_SampleReady,
    input  logic signed [15:0]            i_Sample,
    output logic                          o_BCLK,
    output logic                          o_LRCLK,
    output logic                          o_SDATA,
    output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel,
    output logic                          o_Overflow,
    output logic                          o_Underrun
);

    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [7:0]      DIV_LAST = 8'(CLKS_PER_BCLK_HALF - 1);
    localparam logic [PTR_W:0]  LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    // Divider and bit clock
    logic [7:0]       div_q, div_d;
    logic             bclk_q, bclk_d;

    // Frame state
    logic [4:0]       slot_q, slot_d;
    logic [15:0]      word_q, word_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;

    // FIFO state
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             underrun_q, underrun_d;

    // Decoded events
    logic             div_tc;
    logic             fall_evt;
    logic             pop_req;
    logic             fifo_empty;
    logic             fifo_full;
    logic             do_pop;
    logic             do_push;
    logic [4:0]       slot_m1;
    logic [3:0]       bit_idx;

    // Next-state logic for divider, slot counter, FIFO and serializer
    always_comb begin
        div_tc     = (div_q == DIV_LAST);
        div_d      = div_tc ? 8'd0 : div_q + 8'd1;
        bclk_d     = div_tc ? ~bclk_q : bclk_q;

        // A falling event is the terminal count while BCLK is high.
        fall_evt   = div_tc && bclk_q;
        slot_d     = fall_evt ? slot_q + 5'd1 : slot_q;

        // The slot 0 -> 1 transition starts a new frame and fetches a sample.
        pop_req    = fall_evt && (slot_q == 5'd0);
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_FULL);
        do_pop     = pop_req && !fifo_empty;
        underrun_d = pop_req && fifo_empty;

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push    = i_SampleReady && (!fifo_full || do_pop);
        overflow_d = i_SampleReady && fifo_full && !do_pop;

        word_d     = word_q;
        if (pop_req) begin
            word_d = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
        end

        // Slot s carries bit 15-((s-1) mod 16); 15-x is ~x in four bits.
        slot_m1    = slot_d - 5'd1;
        bit_idx    = ~slot_m1[3:0];
        sdata_d    = fall_evt ? word_d[bit_idx] : sdata_q;
        lrclk_d    = slot_d[4];

        rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;

        level_d    = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            slot_q     <= '0;
            word_q     <= '0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            slot_q     <= slot_d;
            word_q     <= word_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    // FIFO storage write port; contents need no reset since pointers do
    always_ff @(posedge i_Clock) begin
        if (do_push && !i_Reset) begin
            mem_q[wr_ptr_q] <= i_Sample;
        end
    end

    assign o_BCLK      = bclk_q;
    assign o_LRCLK     = lrclk_q;
    assign o_SDATA     = sdata_q;
    assign o_FifoLevel = level_q;
    assign o_Overflow  = overflow_q;
    assign o_Underrun  = underrun_q;

endmodule
